// File: rtl/logic_spi_master_if.sv
// Host-side command/data bus of the SPI master: transaction request, byte streams and status.
interface logic_spi_master_if #(
  parameter int BYTE_WIDTH = 8
);
  logic                  start;
  logic [BYTE_WIDTH-1:0] opcode;
  logic [7:0]            len;
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [BYTE_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, opcode, len, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, opcode, len, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, done
  );
endinterface

// File: rtl/logic_spi_master.sv
// Mode-0, LSB-first SPI master: sends an opcode byte then len data bytes, full duplex,
// with a per-byte fetch handshake so the host may stall between data bytes.
module logic_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  logic_spi_master_if.slave    bus,
  output logic                 spi_nss,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int BW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // GAP needs 2*CLK_DIV counts, so the divider counter is 9 bits for CLK_DIV up to 255.
  localparam logic [8:0]    DIV_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0]    GAP_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BYTE_WIDTH - 1);

  logic [2:0]            state_r;
  logic [8:0]            div_cnt_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [7:0]            remaining_r;
  logic                  opcode_phase_r;
  logic                  loaded_r;
  logic [BYTE_WIDTH-1:0] tx_shift_r;
  logic [BYTE_WIDTH-1:0] rx_shift_r;
  logic [BYTE_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r;
  logic                  tx_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  nss_r;
  logic                  sck_r;
  logic                  mosi_r;

  assign bus.tx_ready = tx_ready_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign spi_nss      = nss_r;
  assign spi_sck      = sck_r;
  assign spi_mosi     = mosi_r;

  // Transaction sequencer, SCK generator and shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      div_cnt_r      <= 9'd0;
      bit_cnt_r      <= {BW{1'b0}};
      remaining_r    <= 8'd0;
      opcode_phase_r <= 1'b0;
      loaded_r       <= 1'b0;
      tx_shift_r     <= {BYTE_WIDTH{1'b0}};
      rx_shift_r     <= {BYTE_WIDTH{1'b0}};
      rx_data_r      <= {BYTE_WIDTH{1'b0}};
      rx_valid_r     <= 1'b0;
      tx_ready_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      nss_r          <= 1'b1;
      sck_r          <= 1'b0;
      mosi_r         <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      tx_ready_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            tx_shift_r     <= bus.opcode;
            remaining_r    <= bus.len;
            opcode_phase_r <= 1'b1;
            busy_r         <= 1'b1;
            nss_r          <= 1'b0;
            mosi_r         <= bus.opcode[0];
            div_cnt_r      <= 9'd0;
            bit_cnt_r      <= {BW{1'b0}};
            state_r        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 9'd0;
            state_r   <= ST_SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end else begin
            div_cnt_r <= 9'd0;
            if (!sck_r) begin
              sck_r      <= 1'b1;
              rx_shift_r <= {spi_miso, rx_shift_r[BYTE_WIDTH-1:1]};
            end else begin
              sck_r <= 1'b0;
              if (bit_cnt_r != BIT_LAST) begin
                bit_cnt_r  <= bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                tx_shift_r <= {1'b0, tx_shift_r[BYTE_WIDTH-1:1]};
                mosi_r     <= tx_shift_r[1];
              end else begin
                // Byte end: the opcode's received bits are simply dropped.
                bit_cnt_r <= {BW{1'b0}};
                if (opcode_phase_r) begin
                  opcode_phase_r <= 1'b0;
                  state_r        <= (remaining_r == 8'd0) ? ST_HOLD : ST_FETCH;
                end else begin
                  rx_data_r   <= rx_shift_r;
                  rx_valid_r  <= 1'b1;
                  remaining_r <= remaining_r - 8'd1;
                  state_r     <= (remaining_r == 8'd1) ? ST_HOLD : ST_FETCH;
                end
              end
            end
          end
        end
        ST_FETCH: begin
          // Stall here with SCK low for as long as the host withholds data.
          if (!loaded_r) begin
            if (bus.tx_valid) begin
              loaded_r   <= 1'b1;
              tx_ready_r <= 1'b1;
              tx_shift_r <= bus.tx_data;
              mosi_r     <= bus.tx_data[0];
              div_cnt_r  <= 9'd0;
            end
          end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 9'd0;
            loaded_r  <= 1'b0;
            state_r   <= ST_SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end
        end
        ST_HOLD: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 9'd0;
            nss_r     <= 1'b1;
            mosi_r    <= 1'b0;
            state_r   <= ST_GAP;
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end
        end
        ST_GAP: begin
          if (div_cnt_r == GAP_LAST) begin
            div_cnt_r <= 9'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + 9'd1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          div_cnt_r <= 9'd0;
          loaded_r  <= 1'b0;
          busy_r    <= 1'b0;
          nss_r     <= 1'b1;
          sck_r     <= 1'b0;
          mosi_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
